// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the register-file writeback scoreboard.
package regfile_pkg;

    localparam int ADDR_W_DEFAULT   = 5;
    localparam int ZERO_REG_DEFAULT = 31;
    localparam int NREGS_DEFAULT    = 2 ** ADDR_W_DEFAULT;

    function automatic logic [NREGS_DEFAULT-1:0] onehot(input logic [ADDR_W_DEFAULT-1:0] addr);
        logic [NREGS_DEFAULT-1:0] v;
        v       = '0;
        v[addr] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/regfile_wb_scoreboard_onehot_decoder.sv
// Combinational ADDR_W-to-2**ADDR_W one-hot decoder with enable.
module onehot_decoder #(
    parameter int ADDR_W = 5,
    localparam int NOUT  = 2 ** ADDR_W
) (
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [NOUT-1:0]   dec_o
);

    for (genvar i = 0; i < NOUT; i++) begin : g_dec
        assign dec_o[i] = en_i && (addr_i == ADDR_W'(i));
    end

endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Registered writeback decode plus per-register busy scoreboard that drives
// issue stalls and source-operand hazard flags.
module regfile_wb_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEFAULT,
    parameter bit HAS_ZERO_REG = 1'b1,
    parameter int ZERO_REG     = ZERO_REG_DEFAULT,
    localparam int NREGS       = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    output logic [NREGS-1:0]  wr_en,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              iss_ready,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              hazard_a,
    output logic              hazard_b,
    output logic [NREGS-1:0]  busy,
    output logic              err_wb_idle
);

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return HAS_ZERO_REG && (a == ADDR_W'(ZERO_REG));
    endfunction

    logic [NREGS-1:0] wr_en_q, wr_en_d;
    logic [NREGS-1:0] busy_q, busy_d;
    logic             err_q, err_d;

    logic             wb_fire, iss_fire, wb_hits_iss;
    logic [NREGS-1:0] wb_mask, set_mask;

    assign wb_fire     = en && wb_valid && !is_zero(wb_addr);
    assign wb_hits_iss = wb_fire && (wb_addr == iss_addr);
    // A busy destination may still issue if its producer retires this same cycle.
    assign iss_ready   = !iss_valid || is_zero(iss_addr) || !busy_q[iss_addr] || wb_hits_iss;
    assign iss_fire    = en && iss_valid && iss_ready && !is_zero(iss_addr);

    onehot_decoder #(.ADDR_W(ADDR_W)) u_wb_dec (
        .en_i   (wb_fire),
        .addr_i (wb_addr),
        .dec_o  (wb_mask)
    );

    onehot_decoder #(.ADDR_W(ADDR_W)) u_iss_dec (
        .en_i   (iss_fire),
        .addr_i (iss_addr),
        .dec_o  (set_mask)
    );

    always_comb begin
        wr_en_d = wb_mask;
        // Set applied after clear so a new producer claims a register retiring now.
        busy_d  = (busy_q & ~wb_mask) | set_mask;
        err_d   = err_q;
        if (wb_fire && !busy_q[wb_addr] && !(iss_fire && (iss_addr == wb_addr)))
            err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_q <= '0;
            busy_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            wr_en_q <= wr_en_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign busy        = busy_q;
    assign err_wb_idle = err_q;
    assign hazard_a    = !is_zero(rd_addr_a) && busy_q[rd_addr_a];
    assign hazard_b    = !is_zero(rd_addr_b) && busy_q[rd_addr_b];

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Directed self-checking bench: default build plus a small ADDR_W=3 build
// without a hardwired zero register.
module tb_regfile_wb_scoreboard;

    logic        clk = 1'b0;
    logic        reset, en;
    logic        wb_valid, iss_valid;
    logic [4:0]  wb_addr, iss_addr, rd_addr_a, rd_addr_b;
    logic [31:0] wr_en, busy;
    logic        iss_ready, hazard_a, hazard_b, err_wb_idle;

    logic        s_wb_valid, s_iss_valid;
    logic [2:0]  s_wb_addr, s_iss_addr, s_rd_a, s_rd_b;
    logic [7:0]  s_wr_en, s_busy;
    logic        s_iss_ready, s_haz_a, s_haz_b, s_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_wb_scoreboard dut (
        .clk(clk), .reset(reset), .en(en),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wr_en(wr_en),
        .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .hazard_a(hazard_a), .hazard_b(hazard_b),
        .busy(busy), .err_wb_idle(err_wb_idle)
    );

    regfile_wb_scoreboard #(.ADDR_W(3), .HAS_ZERO_REG(1'b0)) dut_s (
        .clk(clk), .reset(reset), .en(en),
        .wb_valid(s_wb_valid), .wb_addr(s_wb_addr), .wr_en(s_wr_en),
        .iss_valid(s_iss_valid), .iss_addr(s_iss_addr), .iss_ready(s_iss_ready),
        .rd_addr_a(s_rd_a), .rd_addr_b(s_rd_b),
        .hazard_a(s_haz_a), .hazard_b(s_haz_b),
        .busy(s_busy), .err_wb_idle(s_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; en = 1'b1;
        wb_valid = 1'b1; wb_addr = 5'd3; iss_valid = 1'b0; iss_addr = 5'd0;
        rd_addr_a = 5'd0; rd_addr_b = 5'd0;
        s_wb_valid = 1'b0; s_wb_addr = 3'd0; s_iss_valid = 1'b0; s_iss_addr = 3'd0;
        s_rd_a = 3'd0; s_rd_b = 3'd0;
        tick();
        chk("reset_wr_en", wr_en, 32'h0);
        chk("reset_busy", busy, 32'h0);
        chk("reset_err", 32'(err_wb_idle), 32'h0);

        // Issue to 5, then writeback 5
        reset = 1'b0; wb_valid = 1'b0; iss_valid = 1'b1; iss_addr = 5'd5;
        #1 chk("iss5_ready", 32'(iss_ready), 32'h1);
        tick();
        chk("iss5_busy", busy, 32'h20);
        chk("iss5_wr_en", wr_en, 32'h0);
        iss_valid = 1'b0; wb_valid = 1'b1; wb_addr = 5'd5;
        tick();
        chk("wb5_wr_en", wr_en, 32'h20);
        chk("wb5_busy", busy, 32'h0);
        chk("wb5_err", 32'(err_wb_idle), 32'h0);

        // WAW stall on 7, then same-cycle retire/claim
        wb_valid = 1'b0; iss_valid = 1'b1; iss_addr = 5'd7;
        tick();
        chk("iss7_busy", busy, 32'h80);
        rd_addr_a = 5'd7; rd_addr_b = 5'd31;
        #1;
        chk("waw7_stall", 32'(iss_ready), 32'h0);
        chk("hazard_a7", 32'(hazard_a), 32'h1);
        chk("hazard_b31", 32'(hazard_b), 32'h0);
        tick();
        chk("waw7_busy_held", busy, 32'h80);
        chk("waw7_wr_en", wr_en, 32'h0);
        wb_valid = 1'b1; wb_addr = 5'd7;
        #1 chk("waw7_bypass_ready", 32'(iss_ready), 32'h1);
        chk("hazard_a7_no_bypass", 32'(hazard_a), 32'h1);
        tick();
        chk("setwins7_busy", busy, 32'h80);
        chk("setwins7_wr_en", wr_en, 32'h80);
        chk("setwins7_err", 32'(err_wb_idle), 32'h0);

        // Zero register: issue and writeback both ignored
        iss_addr = 5'd31; wb_addr = 5'd31;
        #1 chk("zero_ready", 32'(iss_ready), 32'h1);
        tick();
        chk("zero_busy", busy, 32'h80);
        chk("zero_wr_en", wr_en, 32'h0);
        chk("zero_err", 32'(err_wb_idle), 32'h0);

        // en=0: nothing changes, status still visible
        en = 1'b0; wb_addr = 5'd7; iss_addr = 5'd9;
        #1 chk("en0_hazard_a", 32'(hazard_a), 32'h1);
        chk("en0_ready9", 32'(iss_ready), 32'h1);
        tick();
        chk("en0_wr_en", wr_en, 32'h0);
        chk("en0_busy", busy, 32'h80);
        chk("en0_err", 32'(err_wb_idle), 32'h0);
        iss_addr = 5'd7;
        #1 chk("en0_ready7_stall", 32'(iss_ready), 32'h0);

        // Retire 7
        en = 1'b1; iss_valid = 1'b0; wb_addr = 5'd7;
        tick();
        chk("clr7_busy", busy, 32'h0);
        chk("clr7_wr_en", wr_en, 32'h80);
        chk("hazard_a_clear", 32'(hazard_a), 32'h0);

        // Idle wb with same-cycle issue to same address: no error
        wb_addr = 5'd4; iss_valid = 1'b1; iss_addr = 5'd4;
        tick();
        chk("wbiss4_busy", busy, 32'h10);
        chk("wbiss4_wr_en", wr_en, 32'h10);
        chk("wbiss4_err", 32'(err_wb_idle), 32'h0);
        iss_valid = 1'b0;
        tick();
        chk("clr4_busy", busy, 32'h0);

        // Idle writeback to 2 raises sticky error
        wb_addr = 5'd2;
        tick();
        chk("idle2_wr_en", wr_en, 32'h4);
        chk("idle2_err", 32'(err_wb_idle), 32'h1);
        wb_valid = 1'b0;
        tick();
        chk("idle2_wr_en_pulse", wr_en, 32'h0);
        tick();
        chk("idle2_err_sticky", 32'(err_wb_idle), 32'h1);

        // Reset mid-operation overrides same-cycle requests
        iss_valid = 1'b1; iss_addr = 5'd6;
        tick();
        chk("iss6_busy", busy, 32'h40);
        reset = 1'b1; wb_valid = 1'b1; wb_addr = 5'd1; iss_addr = 5'd8;
        tick();
        chk("midreset_busy", busy, 32'h0);
        chk("midreset_wr_en", wr_en, 32'h0);
        chk("midreset_err", 32'(err_wb_idle), 32'h0);

        // Small build: register 7 is ordinary
        reset = 1'b0; wb_valid = 1'b0; iss_valid = 1'b0;
        s_iss_valid = 1'b1; s_iss_addr = 3'd7;
        tick();
        chk("small_busy7", 32'(s_busy), 32'h80);
        s_iss_valid = 1'b0; s_wb_valid = 1'b1; s_wb_addr = 3'd7;
        tick();
        chk("small_wr_en7", 32'(s_wr_en), 32'h80);
        chk("small_busy_clr", 32'(s_busy), 32'h0);
        chk("small_err", 32'(s_err), 32'h0);
        s_wb_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
